mem_arbiter: RTL

Shares the single-port unified instruction/data memory between the instruction-fetch requester (driven by the controller's IF phase) and the load/store requester (EX/WB phases). Runs one outstanding transaction at a time with fixed memory read latency. Arbitration is round-robin. Each requester sees a grant pulse followed by a response pulse.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store, with one outstanding access and a fixed read latency.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wstrb,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned CntW = $clog2(MEM_LAT) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  owner_q, owner_d;        // 1 = load/store, 0 = fetch
  logic                  last_owner_q, last_owner_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;

  logic any_req;
  logic eff_last;
  logic pick_ls;
  logic arb;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    arb          = 1'b0;

    any_req  = if_req | ls_req;
    // Leaving RESP, the current owner becomes last_owner at this same edge.
    eff_last = (state_q == StResp) ? owner_q : last_owner_q;
    pick_ls  = ls_req & (~if_req | ~eff_last);

    unique case (state_q)
      StIdle: begin
        if (any_req) arb = 1'b1;
      end
      StIssue: begin
        if (MEM_LAT > 1) begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end else begin
          state_d = StResp;
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) state_d = StResp;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StResp: begin
        last_owner_d = owner_q;
        if (any_req) arb = 1'b1;
        else         state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (arb) begin
      state_d     = StIssue;
      owner_d     = pick_ls;
      mem_addr_d  = pick_ls ? ls_addr : if_addr;
      mem_we_d    = pick_ls & ls_we;
      mem_wdata_d = pick_ls ? ls_wdata : '0;
      mem_wstrb_d = pick_ls ? ls_wstrb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  assign if_gnt    = mem_en & ~owner_q;
  assign ls_gnt    = mem_en & owner_q;
  assign if_rvalid = (state_q == StResp) & ~owner_q;
  assign ls_rvalid = (state_q == StResp) & owner_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid & ~mem_we_q) ? mem_rdata : '0;

endmodule
